register_file_multiport: RTL
============================

// Module: register_file_multiport
// PURPOSE
//  Parametrised successor to the 4x16 single-read-port register file.
//  Provides 2^INDEX_WIDTH registers of WIDTH bits, with two independent read ports (a, b) and one write port.
//  Adds three selectable features: a write-to-read bypass, a hardwired-zero register 0, and an optional registered read stage.
//  Sits in the CPU datapath between decode (which drives the indices) and the ALU operand inputs.
// PARAMETERS
//  WIDTH          16  data width of each register, in bits (>=1)
//  INDEX_WIDTH    2   index width; the register count is 2**INDEX_WIDTH (>=1)
//  BYPASS         0   1 = a read of the index being written in this cycle returns write_data
//  ZERO_REG       0   1 = register 0 always reads 0, and writes to it are discarded
//  READ_LATENCY   0   0 = combinational reads; 1 = read data registered on the rising edge of clk
// PORTS
//  clk            in   1            rising-edge clock
//  reset          in   1            asynchronous, active-high reset
//  read_index_a   in   INDEX_WIDTH  port-a read address
//  read_data_a    out  WIDTH        port-a read data
//  read_index_b   in   INDEX_WIDTH  port-b read address
//  read_data_b    out  WIDTH        port-b read data
//  write_index    in   INDEX_WIDTH  write address
//  write_data     in   WIDTH        write data
//  write_enable   in   1            1 = write write_data to write_index at the rising edge of clk
// BEHAVIOUR
//  Clock and reset
//  - Single clock domain; all state updates on the rising edge of clk.
//  - reset is asynchronous and active-high. While it is asserted:
//    - every register is 0;
//    - the read pipeline registers (READ_LATENCY=1) are 0;
//    - read_data_a and read_data_b read 0 for any index.
//  - Reset takes effect immediately, without waiting for a clock edge, and overrides any write in progress.
//  - A write coinciding with the first edge after reset deasserts is performed normally.
//  Write
//  - At a rising edge with write_enable=1 and reset=0, regs[write_index] <= write_data.
//  - With write_enable=0 all registers hold.
//  - With ZERO_REG=1, writes to index 0 are dropped.
//  Read, READ_LATENCY=0
//  - read_data_x = regs[read_index_x], purely combinational; ports a and b are fully independent.
//  - BYPASS=0: a read of the index being written in the same cycle returns the OLD value; the new value is visible after the edge.
//  - BYPASS=1: if write_enable=1 and read_index_x==write_index, read_data_x = write_data in the same cycle.
//    - The bypass is suppressed when ZERO_REG=1 and the index is 0.
//  Read, READ_LATENCY=1
//  - read_data_x is registered; it reflects the value selected at the previous rising edge.
//  - The value captured at an edge is what the combinational path would have shown just before that edge, bypass rules included.
//  - Consequence: with BYPASS=0, a read issued in the cycle a write lands captures the old value.
//  Zero register
//  - With ZERO_REG=1, index 0 reads 0 on both ports in every mode.
//  Boundary conditions
//  - Index arithmetic is unsigned and covers the full 2**INDEX_WIDTH range; there is no out-of-range case.
//  - Both ports may read the same index simultaneously and return identical data.
//  - Back-to-back writes to the same index: the last write wins.
//  - No X may propagate to outputs from defined inputs.
// TESTING
//  All scenarios use defaults (16-bit, 4 registers) unless stated.
//  1. reset=1, then write 3->r0 and 7->r1 with reset=0:
//     - before the writes, a=r0, b=r1 read 0/0;
//     - after the writes they read 3/7.
//  2. Write 16'hBEEF->r2 and 16'h1234->r3 on consecutive edges, then a=r2, b=r3:
//     - a reads BEEF, b reads 1234;
//     - with a=b=r3, both ports read 1234.
//  3. BYPASS=0 vs BYPASS=1, with write_enable=1, write_index=1, write_data=9, read_index_a=1, r1 previously 5:
//     - before the edge, a reads 5 (BYPASS=0) or 9 (BYPASS=1);
//     - after the edge, a reads 9 in both cases.
//  4. ZERO_REG=1: write 16'hFFFF->r0, with BYPASS=1 also tested:
//     - read of r0 returns 0 both in the write cycle and after it.
//  5. READ_LATENCY=1: r1=7, set read_index_a=1 at edge N:
//     - read_data_a is 7 after edge N+1 and not before.
//  6. Assert reset mid-cycle, asynchronously, while write_enable=1 with r1=7:
//     - all outputs read 0 immediately, before the next edge;
//     - after the next edge all registers are still 0.

Source files
------------

// File: rtl/register_file_multiport.sv
// Multiport register file: 2**INDEX_WIDTH x WIDTH registers, two independent
// read ports (a, b), one write port. Optional write-to-read bypass,
// hardwired-zero r0 and a registered read stage.

// One read port: select, optional bypass/zero override, optional output flop.
module rf_read_port #(
  parameter int WIDTH        = 16,
  parameter int INDEX_WIDTH  = 2,
  parameter int BYPASS       = 0,
  parameter int ZERO_REG     = 0,
  parameter int READ_LATENCY = 0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [(1<<INDEX_WIDTH)-1:0][WIDTH-1:0]  regs,
  input  logic [INDEX_WIDTH-1:0]                  rd_index,
  input  logic [INDEX_WIDTH-1:0]                  wr_index,
  input  logic [WIDTH-1:0]                        wr_data,
  input  logic                                    wr_en,
  output logic [WIDTH-1:0]                        rd_data
);

  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] rd_d;
  logic [WIDTH-1:0] rd_q;

  // Combinational select; zero-register override wins over bypass.
  always_comb begin
    sel = regs[rd_index];
    if (BYPASS != 0 && wr_en && (rd_index == wr_index)) sel = wr_data;
    if (ZERO_REG != 0 && (rd_index == '0))              sel = '0;
  end

  // The registered stage captures exactly what the combinational path shows.
  always_comb begin
    rd_d = sel;
  end

  // Read pipeline register, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  // Outputs are forced to zero while reset is held, so a bypassed write_data
  // cannot leak out during reset.
  always_comb begin
    rd_data = '0;
    if (!reset) rd_data = (READ_LATENCY != 0) ? rd_q : sel;
  end

endmodule

module register_file_multiport #(
  parameter int WIDTH        = 16,
  parameter int INDEX_WIDTH  = 2,
  parameter int BYPASS       = 0,
  parameter int ZERO_REG     = 0,
  parameter int READ_LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] read_index_a,
  output logic [WIDTH-1:0]       read_data_a,
  input  logic [INDEX_WIDTH-1:0] read_index_b,
  output logic [WIDTH-1:0]       read_data_b,
  input  logic [INDEX_WIDTH-1:0] write_index,
  input  logic [WIDTH-1:0]       write_data,
  input  logic                   write_enable
);

  localparam int NUM_REGS = 1 << INDEX_WIDTH;
  localparam int NUM_RD   = 2;

  logic [NUM_REGS-1:0][WIDTH-1:0]    regs_d;
  logic [NUM_REGS-1:0][WIDTH-1:0]    regs_q;
  logic [NUM_RD-1:0][INDEX_WIDTH-1:0] rd_idx;
  logic [NUM_RD-1:0][WIDTH-1:0]       rd_dat;
  logic                               wr_drop;

  // Writes to r0 are discarded when it is hardwired to zero.
  always_comb begin
    wr_drop = (ZERO_REG != 0) && (write_index == '0);
  end

  // Next-state of the array: hold, or update the addressed entry.
  always_comb begin
    regs_d = regs_q;
    if (write_enable && !wr_drop) regs_d[write_index] = write_data;
  end

  // Register array; async reset overrides any write in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  // Port bundling: index 0 is port a, index 1 is port b.
  always_comb begin
    rd_idx[0] = read_index_a;
    rd_idx[1] = read_index_b;
  end

  assign read_data_a = rd_dat[0];
  assign read_data_b = rd_dat[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .WIDTH        (WIDTH),
      .INDEX_WIDTH  (INDEX_WIDTH),
      .BYPASS       (BYPASS),
      .ZERO_REG     (ZERO_REG),
      .READ_LATENCY (READ_LATENCY)
    ) u_port (
      .clk      (clk),
      .reset    (reset),
      .regs     (regs_q),
      .rd_index (rd_idx[p]),
      .wr_index (write_index),
      .wr_data  (write_data),
      .wr_en    (write_enable),
      .rd_data  (rd_dat[p])
    );
  end

endmodule
